gat_bram_host_bridge: RTL and testbench

//  Multi-channel bridge between the byte-addressed host BRAM-controller bus and the word-addressed GAT BRAMs.

---
 rtl/gat_bram_host_bridge.sv | 180 ++++++++++++++++++
 tb/tb_gat_bram_host_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gat_bram_host_bridge.sv
// Host byte-addressed bus to multi-channel word-addressed GAT BRAM bridge.
// Fixed-latency ordered response pipeline, per-channel bounds check and
// per-channel write counting that drives load_done.

// Per-channel load tracker: saturating write counter plus registered done flag.
module gat_bram_load_ctr #(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] len,
    output logic             load_done
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Clear beats a coincident write; saturate rather than wrap.
    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (inc && cnt != '1)
            cnt_nxt = cnt + 1'b1;
    end

    // Done is judged on the post-update count so it rises the cycle after the last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            load_done <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            load_done <= (cnt_nxt >= len) && (len != '0);
        end
    end
endmodule

module gat_bram_host_bridge #(
    parameter int NUM_CH      = 4,
    parameter int MEM_ADDR_W  = 18,
    parameter int MEM_DATA_W  = 20,
    parameter int HOST_DATA_W = 32,
    parameter int BYTE_SHIFT  = 2,
    parameter int HOST_ADDR_W = 22,
    parameter int RD_LATENCY  = 2,
    parameter int SIGN_EXT    = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               core_busy,
    input  logic                               host_req_valid,
    output logic                               host_req_ready,
    input  logic                               host_req_we,
    input  logic [HOST_ADDR_W-1:0]             host_req_addr,
    input  logic [HOST_DATA_W-1:0]             host_req_wdata,
    output logic                               host_rsp_valid,
    output logic [HOST_DATA_W-1:0]             host_rsp_rdata,
    output logic                               host_rsp_err,
    input  logic [NUM_CH*(MEM_ADDR_W+1)-1:0]   ch_len,
    input  logic [NUM_CH-1:0]                  clear_load,
    output logic [NUM_CH-1:0]                  load_done,
    output logic [NUM_CH-1:0]                  mem_en,
    output logic [NUM_CH-1:0]                  mem_we,
    output logic [MEM_ADDR_W-1:0]              mem_addr,
    output logic [MEM_DATA_W-1:0]              mem_wdata,
    input  logic [NUM_CH*MEM_DATA_W-1:0]       mem_rdata
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0][MEM_ADDR_W:0]   len_a;
    logic [NUM_CH-1:0][MEM_DATA_W-1:0] rd_a;
    assign len_a = ch_len;
    assign rd_a  = mem_rdata;

    logic [MEM_ADDR_W-1:0] req_word;
    logic [CH_W-1:0]       req_ch;
    logic [NUM_CH-1:0]     req_onehot;
    logic                  ch_ok;
    logic [MEM_ADDR_W:0]   sel_len;
    logic                  req_err;
    logic                  accept;

    assign req_word   = host_req_addr[BYTE_SHIFT +: MEM_ADDR_W];
    assign req_ch     = host_req_addr[BYTE_SHIFT+MEM_ADDR_W +: CH_W];
    assign req_onehot = NUM_CH'(1) << req_ch;

    // Acceptance is purely combinational from reset and core ownership.
    assign host_req_ready = !rst && !core_busy;
    assign accept         = host_req_valid && host_req_ready;

    // Bounds check: channel must exist and word must sit below that channel's live depth.
    always_comb begin
        ch_ok   = 32'(req_ch) < NUM_CH;
        sel_len = '0;
        if (ch_ok)
            sel_len = len_a[req_ch];
        req_err = !ch_ok || ({1'b0, req_word} >= sel_len);
    end

    // BRAM command register: one-hot enable for exactly one cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= '0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= '0;
            mem_we <= '0;
            if (accept && !req_err) begin
                mem_en    <= req_onehot;
                mem_we    <= host_req_we ? req_onehot : '0;
                mem_addr  <= req_word;
                mem_wdata <= host_req_wdata[MEM_DATA_W-1:0];
            end
        end
    end

    // Response tag pipeline; stage k is valid k+1 cycles after accept, so
    // stage RD_LATENCY lines up with BRAM read data for every request type.
    logic [RD_LATENCY:0]           vld_pipe;
    logic [RD_LATENCY:0]           err_pipe;
    logic [RD_LATENCY:0][CH_W-1:0] ch_pipe;

    // Shift tags down the pipeline; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            ch_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LATENCY-1:0], accept};
            err_pipe <= {err_pipe[RD_LATENCY-1:0], req_err};
            ch_pipe  <= {ch_pipe[RD_LATENCY-1:0], req_ch};
        end
    end

    logic [MEM_DATA_W-1:0] rsp_word;

    // Select the tagged channel's read data; writes and errors return zero.
    always_comb begin
        rsp_word = '0;
        if (vld_pipe[RD_LATENCY] && !err_pipe[RD_LATENCY] && 32'(ch_pipe[RD_LATENCY]) < NUM_CH)
            rsp_word = rd_a[ch_pipe[RD_LATENCY]];
    end

    assign host_rsp_valid = vld_pipe[RD_LATENCY];
    assign host_rsp_err   = vld_pipe[RD_LATENCY] && err_pipe[RD_LATENCY];

    generate
        if (HOST_DATA_W > MEM_DATA_W) begin : g_ext
            logic ext_bit;
            assign ext_bit        = (SIGN_EXT != 0) && rsp_word[MEM_DATA_W-1];
            assign host_rsp_rdata = {{(HOST_DATA_W-MEM_DATA_W){ext_bit}}, rsp_word};
        end else begin : g_noext
            assign host_rsp_rdata = rsp_word;
        end
    endgenerate

    // Per-channel load tracking, counting only in-range accepted writes.
    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            gat_bram_load_ctr #(.CNT_W(MEM_ADDR_W+1)) u_ctr (
                .clk       (clk),
                .rst       (rst),
                .inc       (accept && host_req_we && !req_err && req_onehot[c]),
                .clr       (clear_load[c]),
                .len       (len_a[c]),
                .load_done (load_done[c])
            );
        end
    endgenerate

    // Address low bits and wdata high bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{host_req_addr, host_req_wdata};
endmodule

// File: tb/tb_gat_bram_host_bridge.sv
// Scoreboard bench for gat_bram_host_bridge: directed requests push expected
// responses; a negedge monitor pops and checks data, error flag and arrival cycle.
module tb_gat_bram_host_bridge;
    localparam int NUM_CH = 4;
    localparam int MAW    = 18;
    localparam int MDW    = 20;
    localparam int HDW    = 32;
    localparam int HAW    = 22;
    localparam int RDL    = 2;

    logic clk = 0, rst = 1, core_busy = 0;
    logic host_req_valid = 0, host_req_ready, host_req_we = 0;
    logic [HAW-1:0] host_req_addr = '0;
    logic [HDW-1:0] host_req_wdata = '0;
    logic host_rsp_valid, host_rsp_err;
    logic [HDW-1:0] host_rsp_rdata;
    logic [NUM_CH-1:0][MAW:0] ch_len;
    logic [NUM_CH-1:0] clear_load = '0, load_done, mem_en, mem_we;
    logic [MAW-1:0] mem_addr;
    logic [MDW-1:0] mem_wdata;
    logic [NUM_CH-1:0][MDW-1:0] mem_rdata;

    gat_bram_host_bridge #(
        .NUM_CH(NUM_CH), .MEM_ADDR_W(MAW), .MEM_DATA_W(MDW), .HOST_DATA_W(HDW),
        .BYTE_SHIFT(2), .HOST_ADDR_W(HAW), .RD_LATENCY(RDL), .SIGN_EXT(1)
    ) dut (
        .clk(clk), .rst(rst), .core_busy(core_busy),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_we(host_req_we), .host_req_addr(host_req_addr),
        .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
        .host_rsp_rdata(host_rsp_rdata), .host_rsp_err(host_rsp_err),
        .ch_len(ch_len), .clear_load(clear_load), .load_done(load_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle-latency BRAM model, 256 words per channel
    logic [MDW-1:0] bmem [NUM_CH][256];
    logic [NUM_CH-1:0][MDW-1:0] rd_p1 = '0, rd_p2 = '0;
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (mem_en[c]) begin
                if (mem_we[c]) bmem[c][mem_addr[7:0]] <= mem_wdata;
                else           rd_p1[c] <= bmem[c][mem_addr[7:0]];
            end
        end
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = rd_p2;

    typedef struct { int cyc; logic err; logic [31:0] data; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && host_rsp_valid) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_rsp: got response data %h err %0b at cycle %0d, required none",
                         host_rsp_rdata, host_rsp_err, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_err", {31'd0, host_rsp_err}, {31'd0, e.err});
                chk("rsp_data", host_rsp_rdata, e.data);
            end
        end
    end

    task automatic issue(input logic we, input logic [HAW-1:0] addr, input logic [31:0] wd,
                         input bit push, input logic xerr, input logic [31:0] xdata);
        int g;
        exp_t e;
        host_req_valid = 1; host_req_we = we; host_req_addr = addr; host_req_wdata = wd;
        @(negedge clk);
        g = 0;
        while (!host_req_ready && g < 50) begin @(negedge clk); g++; end
        if (!host_req_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: got ready=0 after 50 cycles, required 1");
        end else if (push) begin
            e.cyc = cyc + 1 + RDL; e.err = xerr; e.data = xdata;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        host_req_valid = 0;
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++)
            for (int w = 0; w < 256; w++) bmem[c][w] = '0;
        bmem[0][0] = 20'h80001;
        bmem[2][7] = 20'h00042;
        ch_len[0] = 19'd16; ch_len[1] = 19'd16; ch_len[2] = 19'd16; ch_len[3] = 19'd4;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, host_req_ready}, 0);
        chk("rst_rsp_valid", {31'd0, host_rsp_valid}, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_load_done", load_done, 0);
        @(posedge clk); #1; rst = 0;

        // Reset mid-burst drops in-flight reads
        issue(0, 22'h000000, 0, 0, 0, 0);
        issue(0, 22'h000004, 0, 0, 0, 0);
        issue(0, 22'h000008, 0, 0, 0, 0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1; rst = 0;
        repeat (4) @(negedge clk);
        chk("post_rst_mem_en", mem_en, 0);
        chk("post_rst_load_done", load_done, 0);
        @(posedge clk); #1;

        // Write ch1 word5
        issue(1, 22'h100014, 32'h000ABCDE, 1, 0, 0);
        chk("wr_mem_en", mem_en, 4'b0010);
        chk("wr_mem_we", mem_we, 4'b0010);
        chk("wr_mem_addr", mem_addr, 5);
        chk("wr_mem_wdata", mem_wdata, 32'hABCDE);

        // Back-to-back reads, sign-extended
        issue(0, 22'h000000, 0, 1, 0, 32'hFFF80001);
        issue(0, 22'h20001C, 0, 1, 0, 32'h00000042);
        // Read back the ch1 write
        issue(0, 22'h100014, 0, 1, 0, 32'hFFFABCDE);

        // Out-of-range write to ch3 (len 4)
        issue(1, 22'h300010, 32'h1, 1, 1, 0);
        chk("err_no_mem_en", mem_en, 0);
        for (int i = 0; i < 4; i++) begin
            issue(1, 22'h300000 | HAW'(i * 4), 32'(i + 1), 1, 0, 0);
            if (i == 2) chk("load_done_after3", {31'd0, load_done[3]}, 0);
        end
        chk("load_done_after4", {31'd0, load_done[3]}, 1);

        // Raising ch_len re-clears done; restoring it re-asserts
        ch_len[3] = 19'd8;
        @(posedge clk); #1;
        chk("len_raise_clears", {31'd0, load_done[3]}, 0);
        ch_len[3] = 19'd4;
        @(posedge clk); #1;
        chk("len_restore_done", {31'd0, load_done[3]}, 1);

        // clear_load coincident with write: clear wins, BRAM write still happens
        clear_load = 4'b1000;
        issue(1, 22'h300004, 32'h55, 1, 0, 0);
        clear_load = 4'b0000;
        chk("clr_wr_mem_en", mem_en, 4'b1000);
        chk("clr_load_done", {31'd0, load_done[3]}, 0);
        for (int i = 0; i < 3; i++) issue(1, 22'h300000 | HAW'(i * 4), 32'h9, 1, 0, 0);
        chk("clr_3writes_not_done", {31'd0, load_done[3]}, 0);
        issue(1, 22'h30000C, 32'h9, 1, 0, 0);
        chk("clr_4writes_done", {31'd0, load_done[3]}, 1);

        // core_busy rising with a response in flight: it still completes
        issue(0, 22'h000000, 0, 1, 0, 32'hFFF80001);
        core_busy = 1;
        repeat (5) @(posedge clk);
        #1;

        // core_busy stalls a held request
        host_req_valid = 1; host_req_we = 0; host_req_addr = 22'h20001C;
        repeat (3) begin
            @(negedge clk);
            chk("busy_ready", {31'd0, host_req_ready}, 0);
            chk("busy_no_en", mem_en, 0);
        end
        @(posedge clk); #1; core_busy = 0;
        @(negedge clk);
        chk("busy_release_ready", {31'd0, host_req_ready}, 1);
        begin
            exp_t e;
            e.cyc = cyc + 1 + RDL; e.err = 0; e.data = 32'h42;
            sb.push_back(e);
        end
        @(posedge clk); #1; host_req_valid = 0;
        chk("busy_release_en", mem_en, 4'b0100);

        repeat (8) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
